// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and the
// even-parity helper used by both the receive and transmit paths.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_rx_state_e;

    // Even-parity bit for a data word: the bit that makes the total count of
    // ones (data plus parity) even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a history flop
// used to detect a falling edge. Every flop resets to 1 (idle line) so that
// leaving reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic sync1;
    logic sync2;
    logic hist;

    // Resynchronise rx into the clk domain and keep one sample of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rx_s    = sync2;
    assign rx_fall = hist & ~sync2;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: start-bit qualification, LSB-first data capture,
// optional even-parity check and stop-bit check, with a one-cycle
// data_ready pulse that updates data_out and the error flags together.
// Optional feature macro: UART_RX_PARITY_EN (11-bit frame with parity).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_en,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   data_ready,
    output logic                   parity_error,
    output logic                   stop_error
);

    // The counter only has to reach CLKS_PER_BIT-1, so it never wraps
    // inside a bit period.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int H     = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_W - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_state_e state_q;
    uart_rx_state_e state_d;

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [2:0]             idx_q;
    logic [2:0]             idx_d;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] shift_d;
    logic                   stop_q;
    logic                   stop_d;
    logic                   deliver_q;
    logic                   deliver_d;
`ifdef UART_RX_PARITY_EN
    logic                   perr_q;
    logic                   perr_d;
`endif

    logic bit_done;
    logic half_done;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign half_done = (cnt_q == HALF_LAST);
    assign bit_done  = (cnt_q == BIT_LAST);

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath updates for each phase of the frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        deliver_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (rx_en && rx_fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    perr_d  = even_parity(shift_q) ^ rx_s;
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    stop_d    = rx_s;
                    deliver_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping the enable abandons the frame without delivering anything.
        if (!rx_en && (state_q != IDLE)) begin
            state_d   = IDLE;
            deliver_d = 1'b0;
        end
    end

    // Bit counter, bit index, shift register and captured frame status.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '1;
            idx_q     <= '1;
            shift_q   <= '0;
            stop_q    <= 1'b1;
            deliver_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            deliver_q <= deliver_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity result of the frame in flight, delivered with the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    // Present the byte and both flags the cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out     <= '0;
            data_ready   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_ready <= deliver_q;
            if (deliver_q) begin
                data_out     <= shift_q;
                parity_error <= perr_q;
                stop_error   <= ~stop_q;
            end
        end
    end
`else
    assign parity_error = 1'b0;

    // Present the byte and the stop flag the cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_ready <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            data_ready <= deliver_q;
            if (deliver_q) begin
                data_out   <= shift_q;
                stop_error <= ~stop_q;
            end
        end
    end
`endif

endmodule
